// File: rtl/fpnew_share_arbiter.sv
// fpnew_share_arbiter: round-robin sharing of one FPU between NumReq requesters with tag-steered responses.
// Optional per-requester in-flight cap enabled by defining FPNEW_ARB_PERREQ_LIMIT_EN.
module fpnew_share_arbiter #(
  parameter int NumReq         = 2,
  parameter int ReqW           = 128,
  parameter int Width          = 32,
  parameter int MaxOutstanding = 4,
  parameter int MaxPerReq      = 2,
  parameter int IdW            = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq-1:0][ReqW-1:0]   req_data_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  input  logic [NumReq-1:0]             rsp_ready_i,
  output logic [NumReq-1:0][Width-1:0]  rsp_result_o,
  output logic [NumReq-1:0][4:0]        rsp_status_o,
  input  logic                          flush_i,
  output logic                          fpu_in_valid_o,
  input  logic                          fpu_in_ready_i,
  output logic [ReqW-1:0]               fpu_req_data_o,
  output logic [IdW-1:0]                fpu_tag_o,
  input  logic                          fpu_out_valid_i,
  output logic                          fpu_out_ready_o,
  input  logic [Width-1:0]              fpu_result_i,
  input  logic [4:0]                    fpu_status_i,
  input  logic [IdW-1:0]                fpu_tag_i,
  output logic                          fpu_flush_o,
  output logic                          busy_o
);
  localparam int CntW = $clog2(MaxOutstanding + 1);

  if (NumReq < 2 || MaxOutstanding < 1 || MaxPerReq < 1) begin : g_bad_cfg
    $error("fpnew_share_arbiter: invalid parameters");
  end

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;
  state_t state, state_nxt;

  logic [IdW-1:0]    ptr, pick, grant, lock_idx;
  logic [CntW-1:0]   count;
  logic [NumReq-1:0] full, elig, load;
  logic              locked, found, have_grant, cap_ok, issue, retire, dec, tag_ok, flush;

  assign flush = flush_i & ~rst_i;
  assign fpu_flush_o = flush;

`ifdef FPNEW_ARB_PERREQ_LIMIT_EN
  localparam int PrW = $clog2(MaxPerReq + 1);
  logic [NumReq-1:0][PrW-1:0] pr_cnt;
  always_comb begin
    for (int k = 0; k < NumReq; k++) elig[k] = req_valid_i[k] & (pr_cnt[k] < PrW'(MaxPerReq));
  end
  assign cap_ok = pr_cnt[grant] < PrW'(MaxPerReq);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pr_cnt <= '0;
    else if (flush) pr_cnt <= '0;
    else
      for (int k = 0; k < NumReq; k++) begin
        if ((issue && int'(grant) == k) && !(retire && tag_ok && int'(fpu_tag_i) == k && pr_cnt[k] != '0))
          pr_cnt[k] <= pr_cnt[k] + 1'b1;
        else if (!(issue && int'(grant) == k) && (retire && tag_ok && int'(fpu_tag_i) == k && pr_cnt[k] != '0))
          pr_cnt[k] <= pr_cnt[k] - 1'b1;
      end
  end
`else
  assign elig = req_valid_i;
  assign cap_ok = 1'b1;
`endif

  // Scan from the farthest offset down so the nearest eligible requester at/after ptr wins.
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--)
      for (int j = 0; j < NumReq; j++)
        if (elig[j] && j == (int'(ptr) + i) % NumReq) begin
          pick = IdW'(j);
          found = 1'b1;
        end
  end

  assign grant = locked ? lock_idx : pick;
  assign have_grant = locked | found;
  assign fpu_in_valid_o = have_grant & ~rst_i & ~flush & (state != FLUSH) & (count < CntW'(MaxOutstanding)) & cap_ok;
  assign issue = fpu_in_valid_o & fpu_in_ready_i;
  assign req_ready_o = issue ? (NumReq'(1) << grant) : '0;
  assign fpu_req_data_o = req_data_i[grant];
  assign fpu_tag_o = grant;

  assign tag_ok = int'(fpu_tag_i) < NumReq;
  assign fpu_out_ready_o = ~tag_ok | ~full[fpu_tag_i] | rsp_ready_i[fpu_tag_i];
  assign retire = fpu_out_valid_i & fpu_out_ready_o;
  assign dec = retire & (issue | (count != '0));
  assign load = (retire & tag_ok) ? (NumReq'(1) << fpu_tag_i) : '0;
  assign rsp_valid_o = full;
  assign busy_o = (count != '0) | (|full);

  always_comb begin
    state_nxt = flush ? FLUSH : (state == FLUSH) ? IDLE : issue ? BUSY :
                (count == '0 && !(|full)) ? IDLE : state;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr <= '0;
      count <= '0;
      locked <= 1'b0;
      lock_idx <= '0;
      full <= '0;
      rsp_result_o <= '0;
      rsp_status_o <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        count <= '0;
        full <= '0;
        locked <= 1'b0;
      end else begin
        locked <= fpu_in_valid_o & ~fpu_in_ready_i;
        lock_idx <= grant;
        if (issue != dec) count <= issue ? count + 1'b1 : count - 1'b1;
        full <= (full & ~rsp_ready_i) | load;
      end
      if (issue) ptr <= (int'(grant) == NumReq - 1) ? '0 : grant + 1'b1;
      if (retire && tag_ok) begin
        rsp_result_o[fpu_tag_i] <= fpu_result_i;
        rsp_status_o[fpu_tag_i] <= fpu_status_i;
      end
    end
  end
endmodule

// File: tb/tb_fpnew_share_arbiter.sv
// tb_fpnew_share_arbiter: directed scenarios then random traffic, checked against a transaction-level model.
module tb_fpnew_share_arbiter;
  localparam int N = 2, RW = 128, W = 32, MO = 4, MP = 2, IW = 1;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][RW-1:0] req_data;
  logic [N-1:0][W-1:0] rsp_result;
  logic [N-1:0][4:0] rsp_status;
  logic flush, fpu_in_valid, fpu_in_ready, fpu_out_valid, fpu_out_ready, fpu_flush, busy;
  logic [RW-1:0] fpu_req_data;
  logic [IW-1:0] fpu_tag, fpu_tag_in;
  logic [W-1:0] fpu_result;
  logic [4:0] fpu_status;

  fpnew_share_arbiter #(.NumReq(N), .ReqW(RW), .Width(W), .MaxOutstanding(MO), .MaxPerReq(MP)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
    .flush_i(flush), .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready), .fpu_req_data_o(fpu_req_data),
    .fpu_tag_o(fpu_tag), .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
    .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_in),
    .fpu_flush_o(fpu_flush), .busy_o(busy));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int m_ptr, m_cnt, m_lidx;
  bit m_lock, m_fl;
  bit [N-1:0] m_full, m_acc;
  logic [W-1:0] m_res[N];
  logic [4:0] m_st[N];
  int m_pr[N];
  int fq[$];
  bit ret;
  logic obs_valid, obs_oready, obs_busy, obs_flush;
  logic [IW-1:0] obs_tag;
  logic [W-1:0] last_res;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pr_ok(input int j);
`ifdef FPNEW_ARB_PERREQ_LIMIT_EN
    return m_pr[j] < MP;
`else
    return j >= 0;
`endif
  endfunction

  function automatic logic [RW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: drive FPU output, compare at negedge, advance the model after the edge.
  task automatic cycle();
    int g, t;
    bit ev, eis, eor, erei;
    logic [N-1:0] eready;
    if (ret && fq.size() > 0) begin
      fpu_out_valid = 1'b1;
      fpu_tag_in = IW'(fq[0]);
      fpu_result = $urandom;
      fpu_status = 5'($urandom);
    end else begin
      fpu_out_valid = 1'b0;
      fpu_tag_in = '0;
    end
    @(negedge clk);
    g = -1;
    if (m_lock) g = m_lidx;
    else
      for (int i = 0; i < N; i++) begin
        int j = (m_ptr + i) % N;
        if (g < 0 && req_valid[j] && pr_ok(j)) g = j;
      end
    ev = (g >= 0) ? (!flush && !m_fl && m_cnt < MO && pr_ok(g)) : 1'b0;
    eis = ev && fpu_in_ready;
    t = int'(fpu_tag_in);
    eor = (t >= N) || !m_full[t] || rsp_ready[t];
    erei = fpu_out_valid && eor;
    eready = eis ? (N'(1) << g) : '0;
    obs_valid = fpu_in_valid; obs_tag = fpu_tag; obs_oready = fpu_out_ready;
    obs_busy = busy; obs_flush = fpu_flush;
    chk("in_valid", fpu_in_valid, ev);
    chk("req_ready", req_ready, eready);
    chk("flush_o", fpu_flush, flush);
    chk("out_ready", fpu_out_ready, eor);
    chk("rsp_valid", rsp_valid, m_full);
    chk("busy", busy, (m_cnt > 0) || (m_full != 0));
    if (ev) begin
      chk("tag", fpu_tag, g);
      chk("data", fpu_req_data, req_data[g]);
    end
    for (int k = 0; k < N; k++)
      if (m_full[k]) begin
        chk("rsp_result", rsp_result[k], m_res[k]);
        chk("rsp_status", rsp_status[k], m_st[k]);
      end
    if (erei) last_res = fpu_result;
    m_acc = eready;
    @(posedge clk);
    #1;
    if (flush) begin
      m_cnt = 0; m_full = '0; m_lock = 0; m_fl = 1;
      for (int k = 0; k < N; k++) m_pr[k] = 0;
      fq.delete();
    end else begin
      m_fl = 0;
      m_cnt = m_cnt + int'(eis) - int'(erei);
      if (m_cnt < 0) m_cnt = 0;
      if (erei) void'(fq.pop_front());
      if (eis) fq.push_back(g);
      for (int k = 0; k < N; k++) begin
        if (erei && t == k) begin
          m_full[k] = 1; m_res[k] = fpu_result; m_st[k] = fpu_status;
        end else if (rsp_ready[k]) m_full[k] = 0;
        if (eis && g == k) m_pr[k]++;
        if (erei && t == k && m_pr[k] > 0) m_pr[k]--;
      end
      m_lock = ev && !fpu_in_ready;
      m_lidx = g;
    end
    if (eis) begin
      m_ptr = (g + 1) % N;
      req_data[g] = rnd_data();
    end
  endtask

  task automatic drain(input int n);
    req_valid = '0; ret = 1; rsp_ready = '1; fpu_in_ready = 1; flush = 0;
    for (int i = 0; i < n; i++) cycle();
    ret = 0;
  endtask

  initial begin
    rst = 1; req_valid = 2'b11; rsp_ready = '0; flush = 0; fpu_in_ready = 1; ret = 0;
    fpu_out_valid = 0; fpu_tag_in = '0; fpu_result = '0; fpu_status = '0;
    for (int k = 0; k < N; k++) begin
      req_data[k] = rnd_data(); m_pr[k] = 0; m_res[k] = '0; m_st[k] = '0;
    end
    m_ptr = 0; m_cnt = 0; m_lidx = 0; m_lock = 0; m_fl = 0; m_full = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_valid", fpu_in_valid, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_flush", fpu_flush, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", rsp_result, '0);
    chk("rst_status", rsp_status, '0);
    @(posedge clk); #1;
    rst = 0;

    rsp_ready = '1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("alt_valid", obs_valid, 1'b1);
      chk("alt_grant", obs_tag, i % 2);
    end
    cycle();
    chk("cap_stall", obs_valid, 1'b0);
    ret = 1;
    cycle();
    chk("cap_stall_retire", obs_valid, 1'b0);
    ret = 0;
    cycle();
    chk("cap_reopen", obs_valid, 1'b1);
    drain(6);

    req_valid = 2'b01; fpu_in_ready = 0;
    cycle();
    chk("lock_first", obs_tag, 0);
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("lock_valid", obs_valid, 1'b1);
      chk("lock_tag", obs_tag, 0);
    end
    fpu_in_ready = 1;
    cycle();
    chk("lock_release", obs_tag, 0);
    req_valid = 2'b10;
    cycle();
    drain(4);

    rsp_ready = '0; req_valid = 2'b10;
    repeat (2) cycle();
    req_valid = '0; ret = 1;
    cycle();
    cycle();
    chk("oready_blocked", obs_oready, 1'b0);
    rsp_ready = 2'b10;
    cycle();
    chk("oready_open", obs_oready, 1'b1);
    chk("new_res", rsp_result[1], last_res);
    chk("new_res_valid", rsp_valid[1], 1'b1);
    drain(4);

    rsp_ready = '0; req_valid = 2'b01;
    cycle();
    req_valid = 2'b11;
    repeat (3) cycle();
    req_valid = '0; ret = 1;
    cycle();
    ret = 0; req_valid = 2'b11; flush = 1;
    cycle();
    chk("flush_pulse", obs_flush, 1'b1);
    chk("flush_no_issue", obs_valid, 1'b0);
    flush = 0;
    cycle();
    chk("flush_state_no_issue", obs_valid, 1'b0);
    chk("flush_state_pulse", obs_flush, 1'b0);
    chk("flush_busy", obs_busy, 1'b0);
    chk("flush_rsp_valid", rsp_valid, 2'b00);
    cycle();
    chk("post_flush_issue", obs_valid, 1'b1);
    drain(6);

`ifdef FPNEW_ARB_PERREQ_LIMIT_EN
    req_valid = 2'b01;
    repeat (2) cycle();
    req_valid = 2'b11;
    cycle();
    chk("perreq_valid", obs_valid, 1'b1);
    chk("perreq_skip", obs_tag, 1);
    drain(6);
`endif

    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++)
        if (!(req_valid[k] && !m_acc[k])) req_valid[k] = $urandom_range(0, 1);
      fpu_in_ready = ($urandom_range(0, 3) != 0);
      ret = ($urandom_range(0, 4) < 3);
      for (int k = 0; k < N; k++) rsp_ready[k] = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 63) == 0);
      cycle();
    end
    drain(8);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
